y86_memsys: RTL and testbench
=============================

# y86_memsys

Parametrised unified byte-addressable memory subsystem for the Y86-64 SEQ processor. It replaces the hard-wired memory hookup with a sized memory that has four parts: a 10-byte instruction fetch port, an 8-byte data port, a streaming program-loader port, and a boot/run/halt controller. The controller gates the CPU and counts executed cycles. It sits beside `Cpu` at the top level and drives the CPU run enable.

## Interface
Parameters:
- MEM_BYTES, 4096: memory size in bytes; must be ≥ 16.
- CNT_W, 32: width of the run-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; **one clock; reset is synchronous and active-high.**
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  marks the final loader byte.
- ld_ready  out  1  loader may transfer this cycle.
- cpu_en  out  1  CPU may advance and write memory.
- cpu_halt  in  1  CPU status is HLT.
- inst_addr  in  64  fetch byte address (the CPU's PC).
- inst  out  80  10 fetched bytes, little-endian.
- imem_error  out  1  fetch out of range.
- mem_addr  in  64  data byte address.
- mem_read  in  1  data read request.
- mem_write  in  1  data write request.
- mem_wdata  in  64  write data, little-endian.
- mem_rdata  out  64  read data, little-endian.
- dmem_error  out  1  data access out of range.
- state  out  2  controller state: 0 LOAD, 1 RUN, 2 HALT, 3 LDERR.
- cycle_count  out  CNT_W  number of cycles spent in RUN.

## Operation
- Reset sets state=LOAD, load pointer=0, cycle_count=0. Memory contents are **not** cleared. Reset asserted mid-RUN returns to LOAD on the next edge, and memory retains the old program.
- ld_ready = (state==LOAD). A byte is accepted when ld_valid && ld_ready. On acceptance, the byte is written to mem[ptr] and ptr increments.
- LOAD→RUN when the accepted byte has ld_last=1 and ptr < MEM_BYTES. That byte is written.
- LOAD→LDERR when a byte is accepted with ptr == MEM_BYTES. That byte is dropped.
- LDERR is sticky until rst. Its outputs are ld_ready=0 and cpu_en=0.
- cpu_en = (state==RUN).
- RUN→HALT when any of cpu_halt, imem_error or (dmem_error && (mem_read||mem_write)) holds in a RUN cycle. HALT is sticky until rst.
- Fetch (combinational): inst[8k+7:8k] = mem[inst_addr+k] for k=0..9.
- Fetch error: imem_error = (inst_addr + 10 > MEM_BYTES), evaluated in 65-bit arithmetic so that address wrap cannot mask the error.
- Out-of-range fetch bytes read as 0.
- Data read (combinational): mem_rdata = 8 bytes at mem_addr, little-endian, when mem_read && !dmem_error. Otherwise mem_rdata = 0.
- Data error: dmem_error = (mem_addr + 8 > MEM_BYTES) in 65-bit arithmetic. It is asserted regardless of read/write request.
- Data write: on the clock edge, all 8 bytes are written when mem_write && cpu_en && !dmem_error. Otherwise no byte changes; there are no partial writes at the boundary.
- If mem_read and mem_write are both high, mem_rdata shows the pre-write contents.
- A fetch that overlaps the bytes being written shows the old bytes until the edge.
- cycle_count increments by 1 on every RUN cycle, including the cycle that transitions to HALT. It saturates at 2^CNT_W−1 and holds in HALT/LOAD/LDERR.

## Timing
- Reset values:
  - ld_ready=1, cpu_en=0, state=0, cycle_count=0.
  - inst, mem_rdata and the error flags are combinational from inputs and memory.
- Fetch and data read have 0-cycle latency, as required by single-cycle SEQ.
- A write is visible to reads in the cycle after the edge.
- A loader byte accepted at edge N is readable in cycle N+1. The ld_last transfer at edge N makes cpu_en=1 from cycle N+1.
- HALT is entered one edge after the halting condition. cpu_en=0 in the following cycle, so no memory write occurs after HALT entry.
- rst has priority over every other event at the same edge, including loader acceptance and halt.

## Test plan
- Load bytes 0x30,0xF0,0x05,0,0,0,0,0,0,0 (irmovq $5,%rax) with ld_last on the 10th byte → state=1 on the next cycle; inst=0x0000000000000005F030 at inst_addr=0; cpu_en=1.
- RUN: write mem_addr=0x100, mem_wdata=0x1122334455667788 → next cycle a read returns the same value; byte 0x100 = 0x88; byte 0x107 = 0x11; a same-cycle read before the edge returns the old data.
- MEM_BYTES=4096: mem_addr=4088 is valid; mem_addr=4089 gives dmem_error=1 with a write suppressed; mem_addr=0xFFFFFFFFFFFFFFFC gives dmem_error=1 (no wrap); inst_addr=4087 gives imem_error=1 → state=2.
- Assert cpu_halt for 1 cycle after 37 RUN cycles → state=2; cycle_count=38 and holds; cpu_en=0; a subsequent mem_write leaves memory unchanged.
- Stream 4097 bytes without ld_last (MEM_BYTES=4096) → state=3 after the 4097th byte; ld_ready=0; mem[4095] holds the 4096th byte.
- Assert rst mid-RUN → state=0, cycle_count=0, ld_ready=1; previously loaded bytes still read back at address 0.

Source files
------------

// File: rtl/y86_memsys.sv
// y86_memsys: unified byte-addressable memory for the Y86-64 SEQ core, with a
// 10-byte fetch port, an 8-byte data port, a streaming loader and a boot/run/halt
// controller that gates the CPU and counts RUN cycles.
// Latency: fetch and data read are combinational (0 cycles); writes and loader bytes
// land on the rising edge and are visible the following cycle.
// Backpressure: o_ld_ready is high only in LOAD; the CPU is stalled via o_cpu_en.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_ld_valid/i_ld_data/i_ld_last, o_ld_ready   program loader byte stream
//   o_cpu_en, i_cpu_halt         CPU run enable, CPU HLT status
//   i_inst_addr, o_inst, o_imem_error            instruction fetch (10 bytes, LE)
//   i_mem_addr, i_mem_read, i_mem_write, i_mem_wdata,
//   o_mem_rdata, o_dmem_error    data port (8 bytes, LE)
//   o_state                      0 LOAD, 1 RUN, 2 HALT, 3 LDERR
//   o_cycle_count                saturating count of RUN cycles
module y86_memsys #(
    parameter int MEM_BYTES = 4096,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ld_valid,
    input  logic [7:0]       i_ld_data,
    input  logic             i_ld_last,
    output logic             o_ld_ready,
    output logic             o_cpu_en,
    input  logic             i_cpu_halt,
    input  logic [63:0]      i_inst_addr,
    output logic [79:0]      o_inst,
    output logic             o_imem_error,
    input  logic [63:0]      i_mem_addr,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [63:0]      i_mem_wdata,
    output logic [63:0]      o_mem_rdata,
    output logic             o_dmem_error,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = AW + 1;  // pointer must be able to hold MEM_BYTES itself
    localparam logic [64:0] MEM_SIZE65 = 65'(MEM_BYTES);
    localparam logic [PW-1:0] PTR_FULL = PW'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_LDERR = 2'd3
    } state_t;

    logic [7:0]       r_mem [MEM_BYTES];
    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_cycle_count;

    logic w_ld_acc;
    logic w_ld_wr;
    logic w_mem_wr;
    logic w_halt_cond;

    // Range checks in 65 bits so an address near 2^64 cannot wrap into range.
    assign o_imem_error = ({1'b0, i_inst_addr} + 65'd10) > MEM_SIZE65;
    assign o_dmem_error = ({1'b0, i_mem_addr} + 65'd8) > MEM_SIZE65;

    // Per-byte fetch: bytes past the end of memory read as zero.
    function automatic logic [7:0] fetch_byte(input logic [64:0] a);
        if (a < MEM_SIZE65) begin
            return r_mem[a[AW-1:0]];
        end
        return 8'h00;
    endfunction

    always_comb begin
        o_inst = '0;
        for (int k = 0; k < 10; k++) begin
            o_inst[8*k +: 8] = fetch_byte({1'b0, i_inst_addr} + 65'(k));
        end
    end

    // Data read; when in range, addr+7 < MEM_BYTES so the AW-bit sum cannot overflow.
    always_comb begin
        o_mem_rdata = '0;
        if (i_mem_read && !o_dmem_error) begin
            for (int k = 0; k < 8; k++) begin
                o_mem_rdata[8*k +: 8] = r_mem[i_mem_addr[AW-1:0] + AW'(k)];
            end
        end
    end

    // Reset blocks every memory update at the same edge.
    assign w_ld_acc    = i_ld_valid && o_ld_ready;
    assign w_ld_wr     = w_ld_acc && (r_ptr < PTR_FULL) && !i_rst;
    assign w_mem_wr    = i_mem_write && o_cpu_en && !o_dmem_error && !i_rst;
    assign w_halt_cond = i_cpu_halt || o_imem_error ||
                         (o_dmem_error && (i_mem_read || i_mem_write));

    // Memory array is deliberately not reset so a program survives rst.
    always_ff @(posedge i_clk) begin
        if (w_ld_wr) begin
            r_mem[r_ptr[AW-1:0]] <= i_ld_data;
        end
        if (w_mem_wr) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[i_mem_addr[AW-1:0] + AW'(k)] <= i_mem_wdata[8*k +: 8];
            end
        end
    end

    // Controller: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Controller: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_ld_acc) begin
                    if (r_ptr == PTR_FULL) begin
                        w_state_nxt = S_LDERR;  // overflow byte is dropped
                    end else if (i_ld_last) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_halt_cond) begin
                    w_state_nxt = S_HALT;
                end
            end
            default: w_state_nxt = r_state;  // HALT and LDERR hold until rst
        endcase
    end

    // Controller: outputs
    always_comb begin
        o_ld_ready = (r_state == S_LOAD);
        o_cpu_en   = (r_state == S_RUN);
        o_state    = r_state;
    end

    // Loader pointer and saturating RUN-cycle counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr         <= '0;
            r_cycle_count <= '0;
        end else begin
            if (w_ld_wr) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if ((r_state == S_RUN) && !(&r_cycle_count)) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
        end
    end

    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_y86_memsys.sv
// tb_y86_memsys: directed checks of loader, controller, fetch/data ports and counter.
// Inputs are driven 1 ns after the rising edge; outputs are sampled 1 ns later.
// Combinational address-range cases are applied from a vector table in HALT.
module tb_y86_memsys;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_en;
    logic        cpu_halt;
    logic [63:0] inst_addr;
    logic [79:0] inst;
    logic        imem_error;
    logic [63:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        dmem_error;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int n_pass  = 0;
    int n_total = 0;

    y86_memsys #(.MEM_BYTES(4096), .CNT_W(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ld_valid   (ld_valid),
        .i_ld_data    (ld_data),
        .i_ld_last    (ld_last),
        .o_ld_ready   (ld_ready),
        .o_cpu_en     (cpu_en),
        .i_cpu_halt   (cpu_halt),
        .i_inst_addr  (inst_addr),
        .o_inst       (inst),
        .o_imem_error (imem_error),
        .i_mem_addr   (mem_addr),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_mem_wdata  (mem_wdata),
        .o_mem_rdata  (mem_rdata),
        .o_dmem_error (dmem_error),
        .o_state      (state),
        .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] maddr;
        logic        mrd;
        logic [63:0] iaddr;
        logic        exp_derr;
        logic        exp_ierr;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t      vt[7];
    logic [7:0] prog[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == 9);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [63:0] exp64;

        prog = '{8'h30, 8'hF0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        //          maddr                  rd    iaddr                  derr  ierr  rdata
        vt[0] = '{64'd4088,               1'b1, 64'd0,                 1'b0, 1'b0, 64'hA5A5A5A5A5A5A5A5};
        vt[1] = '{64'd4089,               1'b1, 64'd4086,              1'b1, 1'b0, 64'h0};
        vt[2] = '{64'hFFFFFFFFFFFFFFFC,   1'b1, 64'd4087,              1'b1, 1'b1, 64'h0};
        vt[3] = '{64'h100,                1'b1, 64'hFFFFFFFFFFFFFFF8,  1'b0, 1'b1, 64'h1122334455667788};
        vt[4] = '{64'h100,                1'b0, 64'd0,                 1'b0, 1'b0, 64'h0};
        vt[5] = '{64'd0,                  1'b1, 64'd0,                 1'b0, 1'b0, 64'h000000000005F030};
        vt[6] = '{64'hFFFFFFFFFFFFFFFF,   1'b1, 64'hFFFFFFFFFFFFFFFA,  1'b1, 1'b1, 64'h0};

        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; cpu_halt = 1'b0;
        inst_addr = '0; mem_addr = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_state", 80'(state), 80'd0);
        chk("rst_ld_ready", 80'(ld_ready), 80'd1);
        chk("rst_cpu_en", 80'(cpu_en), 80'd0);
        chk("rst_count", 80'(cycle_count), 80'd0);

        // Load irmovq $5,%rax
        load_prog();
        chk("load_state", 80'(state), 80'd1);
        chk("load_cpu_en", 80'(cpu_en), 80'd1);
        chk("load_ld_ready", 80'(ld_ready), 80'd0);
        chk("load_inst", inst, 80'h0000000000000005F030);
        chk("load_imem_err", 80'(imem_error), 80'd0);

        // Data write, then write+read in same cycle shows old data
        mem_addr = 64'h100; mem_wdata = 64'h0123456789ABCDEF; mem_write = 1'b1;
        tick();
        mem_wdata = 64'h1122334455667788; mem_read = 1'b1;
        #1;
        chk("rd_before_edge", 80'(mem_rdata), 80'h0123456789ABCDEF);
        tick();
        mem_write = 1'b0;
        #1;
        chk("rd_after_write", 80'(mem_rdata), 80'h1122334455667788);
        inst_addr = 64'h100;
        #1;
        chk("byte_0x100", 80'(inst[7:0]), 80'h88);
        chk("byte_0x107", 80'(inst[63:56]), 80'h11);
        inst_addr = '0;
        mem_addr = 64'd4088; mem_wdata = 64'hA5A5A5A5A5A5A5A5; mem_write = 1'b1;
        #1;
        chk("derr_4088", 80'(dmem_error), 80'd0);
        tick();
        mem_write = 1'b0;
        #1;
        chk("rd_4088", 80'(mem_rdata), 80'hA5A5A5A5A5A5A5A5);
        chk("still_run", 80'(state), 80'd1);
        mem_read = 1'b0;

        // Reset mid-RUN, with a same-edge write that reset must suppress
        rst = 1'b1; mem_addr = 64'h100; mem_wdata = 64'hDEADBEEFDEADBEEF; mem_write = 1'b1;
        tick();
        rst = 1'b0; mem_write = 1'b0; mem_read = 1'b1;
        #1;
        chk("midrst_state", 80'(state), 80'd0);
        chk("midrst_count", 80'(cycle_count), 80'd0);
        chk("midrst_ld_ready", 80'(ld_ready), 80'd1);
        chk("midrst_prog_kept", inst, 80'h0000000000000005F030);
        chk("midrst_wr_blocked", 80'(mem_rdata), 80'h1122334455667788);
        mem_read = 1'b0;

        // 37 RUN cycles, then cpu_halt for one cycle
        load_prog();
        for (int i = 0; i < 37; i++) tick();
        chk("count_37", 80'(cycle_count), 80'd37);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        #1;
        chk("halt_state", 80'(state), 80'd2);
        chk("halt_count", 80'(cycle_count), 80'd38);
        chk("halt_cpu_en", 80'(cpu_en), 80'd0);
        tick(); tick(); tick();
        chk("halt_count_hold", 80'(cycle_count), 80'd38);
        chk("halt_sticky", 80'(state), 80'd2);
        mem_addr = 64'h100; mem_wdata = 64'h0; mem_write = 1'b1;
        tick();
        mem_write = 1'b0; mem_read = 1'b1;
        #1;
        chk("halt_no_write", 80'(mem_rdata), 80'h1122334455667788);
        mem_read = 1'b0;

        // Combinational range vectors (HALT: memory is stable)
        for (int i = 0; i < 7; i++) begin
            mem_addr = vt[i].maddr; mem_read = vt[i].mrd; inst_addr = vt[i].iaddr;
            #1;
            chk($sformatf("vec%0d_derr", i), 80'(dmem_error), 80'(vt[i].exp_derr));
            chk($sformatf("vec%0d_ierr", i), 80'(imem_error), 80'(vt[i].exp_ierr));
            chk($sformatf("vec%0d_rdata", i), 80'(mem_rdata), 80'(vt[i].exp_rdata));
        end
        inst_addr = 64'hFFFFFFFFFFFFFFF8;
        #1;
        chk("inst_oob_zero", inst, 80'h0);
        inst_addr = 64'd4090;
        #1;
        chk("inst_tail_zero", 80'(inst[79:48]), 80'h0);
        chk("inst_tail_data", 80'(inst[47:0]), 80'hA5A5A5A5A5A5);
        inst_addr = '0; mem_read = 1'b0;

        // Out-of-range write in RUN: suppressed, and halts
        do_reset();
        load_prog();
        mem_addr = 64'd4089; mem_wdata = 64'h0; mem_write = 1'b1;
        #1;
        chk("derr_4089", 80'(dmem_error), 80'd1);
        tick();
        mem_write = 1'b0;
        mem_addr = 64'd4088; mem_read = 1'b1;
        #1;
        chk("derr_halt", 80'(state), 80'd2);
        chk("no_partial_write", 80'(mem_rdata), 80'hA5A5A5A5A5A5A5A5);
        mem_read = 1'b0;

        // Fetch out of range in RUN halts
        do_reset();
        load_prog();
        inst_addr = 64'd4087;
        #1;
        chk("ierr_4087", 80'(imem_error), 80'd1);
        tick();
        chk("ierr_halt", 80'(state), 80'd2);
        chk("ierr_count", 80'(cycle_count), 80'd1);
        inst_addr = '0;

        // Loader overflow: 4097 bytes with no ld_last
        do_reset();
        for (int i = 0; i < 4097; i++) begin
            if (i == 4096) begin
                chk("ovf_pre_state", 80'(state), 80'd0);
                chk("ovf_pre_ready", 80'(ld_ready), 80'd1);
            end
            ld_valid = 1'b1;
            ld_data  = 8'(i) ^ 8'h5A;
            tick();
        end
        ld_valid = 1'b0;
        mem_addr = 64'd4088; mem_read = 1'b1;
        #1;
        chk("ovf_state", 80'(state), 80'd3);
        chk("ovf_ld_ready", 80'(ld_ready), 80'd0);
        chk("ovf_cpu_en", 80'(cpu_en), 80'd0);
        for (int k = 0; k < 8; k++) exp64[8*k +: 8] = 8'(4088 + k) ^ 8'h5A;
        chk("ovf_tail_bytes", 80'(mem_rdata), 80'(exp64));
        tick(); tick();
        chk("lderr_sticky", 80'(state), 80'd3);
        chk("lderr_count", 80'(cycle_count), 80'd0);
        mem_read = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
